// File: rtl/regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_bank
// Purpose  : Write side of the MIPS register file. Decodes the write address
//            into a one-hot enable, holds the 32 architectural registers and
//            exposes them on a flat bus that feeds the two 32:1 read muxes.
//
// Ports    : clk            - single clock, rising-edge state updates
//            reset          - asynchronous, active-low reset
//            RegWrite       - write enable from the control unit
//            WriteReg[4:0]  - destination register number
//            WriteData      - value to write (WIDTH bits)
//            Dec_onehot[31:0] - combinational one-hot write decode
//                               (bit 0 always 0)
//            Q_flat         - register n at Q_flat[n*WIDTH +: WIDTH]
//            last_wr_valid  - 1 in the cycle after a committed write
//            last_wr_addr   - address of the most recent committed write
//
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_bank #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [WIDTH-1:0] GP_INIT = 32'h1000_8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic [4:0]          WriteReg,
  input  logic [WIDTH-1:0]    WriteData,
  output logic [31:0]         Dec_onehot,
  output logic [32*WIDTH-1:0] Q_flat,
  output logic                last_wr_valid,
  output logic [4:0]          last_wr_addr
);

  localparam int c_GP_REG = 28;
  localparam int c_SP_REG = 29;

  logic [31:0] w_dec;
  logic        w_commit;
  logic        r_last_wr_valid;
  logic [4:0]  r_last_wr_addr;

  // $zero has no storage and never decodes as a write target.
  assign w_dec[0] = 1'b0;

  genvar n;
  generate
    for (n = 1; n < 32; n++) begin : g_dec
      assign w_dec[n] = RegWrite & (WriteReg == 5'(n));
    end
  endgenerate

  // A write to address 0 decodes to nothing, so "any enable high" is exactly
  // the committed-write condition.
  assign w_commit   = |w_dec;
  assign Dec_onehot = w_dec;

  assign Q_flat[WIDTH-1:0] = '0;

  generate
    for (n = 1; n < 32; n++) begin : g_reg
      // $gp and $sp come out of reset pointing at the data/stack segments.
      localparam logic [WIDTH-1:0] c_RST_VAL =
        (n == c_GP_REG) ? GP_INIT :
        (n == c_SP_REG) ? SP_INIT : '0;

      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_q <= c_RST_VAL;
        end else if (w_dec[n]) begin
          r_q <= WriteData;
        end
      end

      assign Q_flat[n*WIDTH +: WIDTH] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_wr_valid <= 1'b0;
      r_last_wr_addr  <= 5'd0;
    end else begin
      r_last_wr_valid <= w_commit;
      if (w_commit) begin
        r_last_wr_addr <= WriteReg;
      end
    end
  end

  assign last_wr_valid = r_last_wr_valid;
  assign last_wr_addr  = r_last_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_bank
// Purpose  : Self-checking bench for regfile_write_bank. A register-array
//            model tracks the architectural state; a negedge process compares
//            every DUT output with it each cycle, and directed scenarios add
//            literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_bank;

  localparam int WIDTH = 32;

  logic                clk;
  logic                reset;
  logic                RegWrite;
  logic [4:0]          WriteReg;
  logic [WIDTH-1:0]    WriteData;
  logic [31:0]         Dec_onehot;
  logic [32*WIDTH-1:0] Q_flat;
  logic                last_wr_valid;
  logic [4:0]          last_wr_addr;

  regfile_write_bank #(
    .WIDTH   (WIDTH),
    .SP_INIT (32'h7FFF_EFFC),
    .GP_INIT (32'h1000_8000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .Dec_onehot    (Dec_onehot),
    .Q_flat        (Q_flat),
    .last_wr_valid (last_wr_valid),
    .last_wr_addr  (last_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] qreg(input int idx);
    return Q_flat[idx*WIDTH +: WIDTH];
  endfunction

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_reg [32];
  logic             m_lv;
  logic [4:0]       m_la;

  always @(negedge reset) begin
    for (int i = 0; i < 32; i++) m_reg[i] <= '0;
    m_reg[28] <= 32'h1000_8000;
    m_reg[29] <= 32'h7FFF_EFFC;
    m_lv <= 1'b0;
    m_la <= 5'd0;
  end

  always @(posedge clk) begin
    if (reset) begin
      if (RegWrite && WriteReg != 5'd0) begin
        m_reg[WriteReg] <= WriteData;
        m_lv <= 1'b1;
        m_la <= WriteReg;
      end else begin
        m_lv <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_dec();
    if (RegWrite && WriteReg != 5'd0) return 32'd1 << WriteReg;
    return 32'd0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("dec_onehot", Dec_onehot, exp_dec());
      for (int i = 0; i < 32; i++)
        chk($sformatf("q_reg%0d", i), qreg(i), m_reg[i]);
      chk("last_wr_valid", {31'd0, last_wr_valid}, {31'd0, m_lv});
      chk("last_wr_addr", {27'd0, last_wr_addr}, {27'd0, m_la});
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d);
    RegWrite  = we;
    WriteReg  = a;
    WriteData = d;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] v;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0);
    #1 reset = 1'b0;
    check_en = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_reg29", qreg(29), 32'h7FFF_EFFC);
    chk("rst_reg28", qreg(28), 32'h1000_8000);
    chk("rst_reg5", qreg(5), 32'h0);
    chk("rst_lv", {31'd0, last_wr_valid}, 32'd0);
    chk("rst_la", {27'd0, last_wr_addr}, 32'd0);
    reset = 1'b1;

    // Write sweep
    for (int n = 1; n < 32; n++) begin
      v = 32'hA500_0000 | 32'(n);
      drive(1'b1, 5'(n), v);
      #1 chk($sformatf("sweep_dec%0d", n), Dec_onehot, 32'd1 << n);
      step();
      chk($sformatf("sweep_reg%0d", n), qreg(n), v);
      chk("sweep_la", {27'd0, last_wr_addr}, 32'(n));
      chk("sweep_lv", {31'd0, last_wr_valid}, 32'd1);
    end

    // $zero write is discarded
    drive(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1 chk("zero_dec", Dec_onehot, 32'd0);
    step();
    chk("zero_reg0", qreg(0), 32'd0);
    chk("zero_lv", {31'd0, last_wr_valid}, 32'd0);
    chk("zero_reg31", qreg(31), 32'hA500_001F);

    // Gated write
    drive(1'b0, 5'd5, 32'hDEAD_BEEF);
    #1 chk("gated_dec", Dec_onehot, 32'd0);
    step();
    chk("gated_reg5", qreg(5), 32'hA500_0005);
    chk("gated_lv", {31'd0, last_wr_valid}, 32'd0);

    // Back-to-back writes to reg 7
    drive(1'b1, 5'd7, 32'h1111_1111);
    step();
    chk("b2b_first", qreg(7), 32'h1111_1111);
    chk("b2b_lv1", {31'd0, last_wr_valid}, 32'd1);
    drive(1'b1, 5'd7, 32'h2222_2222);
    step();
    chk("b2b_second", qreg(7), 32'h2222_2222);
    chk("b2b_lv2", {31'd0, last_wr_valid}, 32'd1);

    // Async reset in the middle of a write
    drive(1'b1, 5'd29, 32'h0000_0100);
    step();
    chk("ar_reg29_wr", qreg(29), 32'h0000_0100);
    drive(1'b1, 5'd29, 32'h0000_0200);
    reset = 1'b0;
    #1;
    chk("ar_reg29_rst", qreg(29), 32'h7FFF_EFFC);
    chk("ar_reg7_rst", qreg(7), 32'h0);
    chk("ar_lv", {31'd0, last_wr_valid}, 32'd0);
    chk("ar_la", {27'd0, last_wr_addr}, 32'd0);
    #1;
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h0000_0003);
    step();
    chk("ar_post_reg3", qreg(3), 32'h0000_0003);
    chk("ar_post_lv", {31'd0, last_wr_valid}, 32'd1);
    chk("ar_post_la", {27'd0, last_wr_addr}, 32'd3);
    chk("ar_post_reg29", qreg(29), 32'h7FFF_EFFC);

    // Randomized traffic with occasional reset pulses
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 32), $urandom);
      if ($urandom % 50 == 0) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      step();
    end

    drive(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_bank.md
# regfile_write_bank

Write side of the MIPS register file. Decodes a 5-bit write address into a one-hot enable, holds the 32 architectural registers and presents them on a flat bus feeding the 32-to-1 read multiplexers. Sits between the write-back stage of the multi-cycle datapath (RegDst/MemtoReg selection) and the two read-port muxes.

## Interface
Parameters:
- WIDTH, 32, register width in bits
- SP_INIT, 32'h7FFF_EFFC, reset value of $sp (register 29)
- GP_INIT, 32'h1000_8000, reset value of $gp (register 28)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserting it clears state immediately, regardless of clk
- RegWrite  input  1  write enable from control unit
- WriteReg  input  5  destination register number
- WriteData  input  WIDTH  value to write
- Dec_onehot  output  32  combinational decode; bit n = RegWrite & (WriteReg == n) for n = 1..31; bit 0 always 0
- Q_flat  output  32*WIDTH  register n on Q_flat[n*WIDTH +: WIDTH]
- last_wr_valid  output  1  registered: 1 in the cycle after a committed write
- last_wr_addr  output  5  registered: address of the most recent committed write

## Operation
- Decoder: 5-to-32 one-hot, gated by RegWrite. At most one bit of Dec_onehot high at any time.
- Storage: 32 WIDTH-bit registers. Register n loads WriteData on rising clk when Dec_onehot[n] = 1; otherwise holds.
- Register 0 ($zero): no storage; Q_flat slice 0 is constant 0. Writes to address 0 are discarded and are not committed writes.
- Committed write: RegWrite = 1 and WriteReg != 0 at a rising edge.
- last_wr_valid: loads 1 on a committed write, 0 otherwise (including RegWrite with WriteReg = 0).
- last_wr_addr: loads WriteReg on a committed write; holds otherwise.
- WriteReg/WriteData are don't-care when RegWrite = 0; no state changes.
- No arithmetic; data stored bit-exact, no extension or truncation.

Reset values (reset = 0, asynchronous):
- registers 1..27, 30, 31 = 0
- register 28 = GP_INIT, register 29 = SP_INIT
- last_wr_valid = 0, last_wr_addr = 0
- Dec_onehot follows inputs (combinational) even during reset; no write occurs while reset is low.

## Timing
- Write latency: data on Q_flat the cycle after the capturing edge. No write-to-read bypass; a same-cycle read of the written register returns the old value.
- Dec_onehot: purely combinational, zero-cycle.
- last_wr_valid / last_wr_addr update on the same edge as the register write.
- Reset mid-operation: assertion overrides any write in flight at once; Q_flat shows reset values within the same cycle. Deassertion is synchronous-safe: first write can commit on the first rising edge with reset = 1.
- Back-to-back writes to the same register on consecutive edges: each commits; last value wins.
- Writes to 28 or 29 override their reset values normally.

## Test plan
- Reset: hold reset = 0 for 3 cycles -> Q_flat reg29 = 32'h7FFF_EFFC, reg28 = 32'h1000_8000, all others 0, last_wr_valid = 0, last_wr_addr = 0.
- Write sweep: for n = 1..31 write 32'hA500_0000 | n -> after each edge only reg n changes, Dec_onehot = 1<<n during the write cycle, last_wr_addr = n, last_wr_valid = 1.
- $zero: RegWrite = 1, WriteReg = 0, WriteData = 32'hFFFF_FFFF -> reg0 stays 0, Dec_onehot = 0, last_wr_valid = 0 next cycle, other registers unchanged.
- Gated write: RegWrite = 0, WriteReg = 5, WriteData = 32'hDEAD_BEEF -> reg5 unchanged, Dec_onehot = 0, last_wr_valid = 0.
- Back-to-back: write reg 7 = 32'h1111_1111 then reg 7 = 32'h2222_2222 on next edge -> reg 7 reads 32'h1111_1111 then 32'h2222_2222; last_wr_valid stays 1 both cycles.
- Async reset mid-write: reg 29 written 32'h0000_0100, then reset pulsed low between edges -> reg29 returns to 32'h7FFF_EFFC before next edge, last_wr_valid = 0; first post-reset write to reg 3 = 32'h0000_0003 commits on first edge with reset = 1.
